// File: rtl/ofm_requant_if.sv
// Handshake bundle between the PE array, the requant stage and the OFM buffer.
// The slave modport is the requant stage's view; master is the surrounding logic.
interface ofm_requant_if #(
    parameter int ACC_W   = 24,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 5
) ();
    logic               psum_valid;
    logic               psum_ready;
    logic [ACC_W-1:0]   psum_data;
    logic               psum_last;
    logic [ACC_W-1:0]   bias;
    logic [SCALE_W-1:0] scale;
    logic [SHIFT_W-1:0] shift;
    logic               relu_en;
    logic               ofm_valid;
    logic               ofm_ready;
    logic [7:0]         ofm_data;

    modport slave (
        input  psum_valid, psum_data, psum_last, bias, scale, shift, relu_en, ofm_ready,
        output psum_ready, ofm_valid, ofm_data
    );

    modport master (
        output psum_valid, psum_data, psum_last, bias, scale, shift, relu_en, ofm_ready,
        input  psum_ready, ofm_valid, ofm_data
    );
endinterface

// File: rtl/ofm_requant_pipe.sv
// Per-pixel psum accumulation followed by bias, ReLU, fixed-point rescale and int8 saturation.
// Stages: A accumulate -> B bias/ReLU -> C multiply -> output round/clamp; a stalled output freezes everything.
module ofm_requant_pipe #(
    parameter int ACC_W   = 24,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    ofm_requant_if.slave     bus,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] pix_cnt,
    output logic             sat_flag
);
    localparam int XW = ACC_W + 1;
    localparam int PW = ACC_W + SCALE_W + 2;
    localparam logic signed [PW:0] SAT_HI = (PW+1)'(127);
    localparam logic signed [PW:0] SAT_LO = (PW+1)'(-128);

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    first_q, first_d;
    logic                    b_valid_q, b_valid_d;
    logic signed [XW-1:0]    b_x_q, b_x_d;
    logic [SCALE_W-1:0]      b_scale_q, b_scale_d;
    logic [SHIFT_W-1:0]      b_shift_q, b_shift_d;
    logic                    c_valid_q, c_valid_d;
    logic signed [PW-1:0]    c_p_q, c_p_d;
    logic [SHIFT_W-1:0]      c_shift_q, c_shift_d;
    logic                    ofm_valid_q, ofm_valid_d;
    logic [7:0]              ofm_data_q, ofm_data_d;
    logic [CNT_W-1:0]        pix_cnt_q, pix_cnt_d;
    logic                    sat_q, sat_d;

    logic                    stall;
    logic                    accept;
    logic                    handshake;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [XW-1:0]    x_val;
    logic signed [PW-1:0]    prod;
    logic [PW:0]             rnd;
    logic signed [PW:0]      sum_r;
    logic signed [PW:0]      r_val;
    logic [7:0]              clamp_val;
    logic                    clamped;

    assign stall     = ofm_valid_q & ~bus.ofm_ready;
    assign accept    = bus.psum_valid & ~stall;
    assign handshake = ofm_valid_q & bus.ofm_ready;

    assign bus.psum_ready = ~stall;
    assign bus.ofm_valid  = ofm_valid_q;
    assign bus.ofm_data   = ofm_data_q;
    assign pix_cnt        = pix_cnt_q;
    assign sat_flag       = sat_q;

    always_comb begin
        acc_sum = (first_q ? '0 : acc_q) + bus.psum_data;
        x_val   = XW'(acc_sum) + XW'($signed(bus.bias));
        if (bus.relu_en && x_val[XW-1]) begin
            x_val = '0;
        end

        prod = PW'(b_x_q) * PW'($signed({1'b0, b_scale_q}));

        // Half-LSB rounding bias; zero when no shift is applied.
        rnd   = ({{PW{1'b0}}, 1'b1} << c_shift_q) >> 1;
        sum_r = (PW+1)'(c_p_q) + rnd;
        r_val = sum_r >>> c_shift_q;

        clamp_val = r_val[7:0];
        clamped   = 1'b0;
        if (r_val > SAT_HI) begin
            clamp_val = 8'h7f;
            clamped   = 1'b1;
        end else if (r_val < SAT_LO) begin
            clamp_val = 8'h80;
            clamped   = 1'b1;
        end

        acc_d       = acc_q;
        first_d     = first_q;
        b_valid_d   = b_valid_q;
        b_x_d       = b_x_q;
        b_scale_d   = b_scale_q;
        b_shift_d   = b_shift_q;
        c_valid_d   = c_valid_q;
        c_p_d       = c_p_q;
        c_shift_d   = c_shift_q;
        ofm_valid_d = ofm_valid_q;
        ofm_data_d  = ofm_data_q;
        pix_cnt_d   = pix_cnt_q;
        sat_d       = sat_q;

        if (!stall) begin
            if (accept) begin
                if (bus.psum_last) begin
                    acc_d     = '0;
                    first_d   = 1'b1;
                    b_x_d     = x_val;
                    b_scale_d = bus.scale;
                    b_shift_d = bus.shift;
                end else begin
                    acc_d     = acc_sum;
                    first_d   = 1'b0;
                end
            end
            b_valid_d = accept & bus.psum_last;

            c_valid_d = b_valid_q;
            if (b_valid_q) begin
                c_p_d     = prod;
                c_shift_d = b_shift_q;
            end

            ofm_valid_d = c_valid_q;
            if (c_valid_q) begin
                ofm_data_d = clamp_val;
                if (clamped) begin
                    sat_d = 1'b1;
                end
            end
        end

        if (handshake) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end

        // A clear outranks any same-cycle handshake or saturation event.
        if (stat_clr) begin
            pix_cnt_d = '0;
            sat_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            b_valid_q   <= 1'b0;
            b_x_q       <= '0;
            b_scale_q   <= '0;
            b_shift_q   <= '0;
            c_valid_q   <= 1'b0;
            c_p_q       <= '0;
            c_shift_q   <= '0;
            ofm_valid_q <= 1'b0;
            ofm_data_q  <= '0;
            pix_cnt_q   <= '0;
            sat_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            first_q     <= first_d;
            b_valid_q   <= b_valid_d;
            b_x_q       <= b_x_d;
            b_scale_q   <= b_scale_d;
            b_shift_q   <= b_shift_d;
            c_valid_q   <= c_valid_d;
            c_p_q       <= c_p_d;
            c_shift_q   <= c_shift_d;
            ofm_valid_q <= ofm_valid_d;
            ofm_data_q  <= ofm_data_d;
            pix_cnt_q   <= pix_cnt_d;
            sat_q       <= sat_d;
        end
    end
endmodule

// File: tb/tb_ofm_requant_pipe.sv
// Bench for ofm_requant_pipe: directed scenarios plus randomized pixels with random backpressure,
// scored against a pixel-level arithmetic model of the requantization.
module tb_ofm_requant_pipe;
    localparam int ACC_W   = 24;
    localparam int SCALE_W = 16;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             stat_clr;
    logic [CNT_W-1:0] pix_cnt;
    logic             sat_flag;

    ofm_requant_if #(.ACC_W(ACC_W), .SCALE_W(SCALE_W), .SHIFT_W(SHIFT_W)) bus ();

    ofm_requant_pipe #(.ACC_W(ACC_W), .SCALE_W(SCALE_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .stat_clr (stat_clr),
        .pix_cnt  (pix_cnt),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    int     compared   = 0;
    int     mismatched = 0;
    longint m_acc      = 0;
    longint exp_q[$];
    longint last_out   = 0;
    int     exp_pix    = 0;
    int     cyc        = 0;
    int     stall_start = 1000000;
    int     stall_len   = 0;
    bit     rand_bp     = 1'b0;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint wrapAcc(input longint v);
        logic signed [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return longint'(t);
    endfunction

    // Whole-pixel reference: bias, ReLU, scale, round-half-up shift, clamp to int8.
    function automatic longint requant(input longint acc, input longint bias, input longint scale,
                                       input int shift, input bit relu);
        longint x;
        longint p;
        x = acc + bias;
        if (relu && x < 0) x = 0;
        p = x * scale;
        if (shift > 0) p = (p + (longint'(1) <<< (shift - 1))) >>> shift;
        if (p > 127) p = 127;
        if (p < -128) p = -128;
        return p;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input longint data, input bit last, input longint bias,
                                 input longint scale, input int shift, input bit relu);
        int waited = 0;
        bit taken  = 1'b0;
        bus.psum_valid = 1'b1;
        bus.psum_data  = data[ACC_W-1:0];
        bus.psum_last  = last;
        bus.bias       = bias[ACC_W-1:0];
        bus.scale      = scale[SCALE_W-1:0];
        bus.shift      = SHIFT_W'(shift);
        bus.relu_en    = relu;
        while (!taken && waited < 200) begin
            @(negedge clk);
            taken = bus.psum_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.psum_valid = 1'b0;
        if (!taken) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            m_acc = wrapAcc(m_acc + data);
            if (last) begin
                exp_q.push_back(requant(m_acc, bias, scale, shift, relu));
                m_acc = 0;
            end
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.ofm_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) checkOutput("drain_timeout", longint'(exp_q.size()), 0);
        idle(1);
    endtask

    initial begin
        bus.ofm_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rand_bp) bus.ofm_ready = ($urandom_range(0, 3) != 0);
            else         bus.ofm_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
        end
    end

    // Scoreboard: every visible output must match the oldest pending pixel, held or not.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pix = 0;
            end else begin
                checkOutput("pix_cnt", longint'(pix_cnt), longint'(exp_pix));
                checkOutput("psum_ready", longint'(bus.psum_ready),
                            longint'(!(bus.ofm_valid && !bus.ofm_ready)));
                if (bus.ofm_valid) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("spurious_ofm", 1, 0);
                    end else begin
                        checkOutput("ofm_data", longint'($signed(bus.ofm_data)), exp_q[0]);
                        if (bus.ofm_ready) begin
                            last_out = longint'($signed(bus.ofm_data));
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (stat_clr) exp_pix = 0;
                else if (bus.ofm_valid && bus.ofm_ready) exp_pix = (exp_pix + 1) % (1 << CNT_W);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        longint d;
        longint bias_r;
        longint scale_r;
        int     shift_r;
        bit     relu_r;
        int     nt;
        logic signed [ACC_W-1:0] r24;

        rst            = 1'b1;
        stat_clr       = 1'b0;
        bus.psum_valid = 1'b0;
        bus.psum_data  = '0;
        bus.psum_last  = 1'b0;
        bus.bias       = '0;
        bus.scale      = '0;
        bus.shift      = '0;
        bus.relu_en    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ofm_valid", longint'(bus.ofm_valid), 0);
        checkOutput("rst_ofm_data", longint'(bus.ofm_data), 0);
        checkOutput("rst_pix_cnt", longint'(pix_cnt), 0);
        checkOutput("rst_sat_flag", longint'(sat_flag), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("psum_ready_after_rst", longint'(bus.psum_ready), 1);
        @(posedge clk);
        #1;

        applyStimulus(10, 0, 5, 1, 0, 0);
        applyStimulus(20, 0, 5, 1, 0, 0);
        applyStimulus(30, 1, 5, 1, 0, 0);
        @(negedge clk);
        checkOutput("lat_cycle1_valid", longint'(bus.ofm_valid), 0);
        @(negedge clk);
        checkOutput("lat_cycle2_valid", longint'(bus.ofm_valid), 0);
        @(negedge clk);
        checkOutput("lat_cycle3_valid", longint'(bus.ofm_valid), 1);
        checkOutput("lat_cycle3_data", longint'($signed(bus.ofm_data)), 65);
        @(posedge clk);
        #1;
        waitDrain();
        checkOutput("t1_pix_cnt", longint'(pix_cnt), 1);

        applyStimulus(-100, 1, 0, 1, 0, 1);
        waitDrain();
        checkOutput("relu_on", last_out, 0);
        applyStimulus(-100, 1, 0, 1, 0, 0);
        waitDrain();
        checkOutput("relu_off", last_out, -100);

        applyStimulus(7, 1, 0, 3, 2, 0);
        waitDrain();
        checkOutput("round_pos", last_out, 5);
        applyStimulus(-7, 1, 0, 3, 2, 0);
        waitDrain();
        checkOutput("round_neg", last_out, -5);
        checkOutput("sat_clear_before_sat", longint'(sat_flag), 0);

        applyStimulus(1000, 1, 0, 1, 0, 0);
        waitDrain();
        checkOutput("sat_pos", last_out, 127);
        checkOutput("sat_flag_set", longint'(sat_flag), 1);
        applyStimulus(-1000, 1, 0, 1, 0, 0);
        waitDrain();
        checkOutput("sat_neg", last_out, -128);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        idle(1);
        checkOutput("clr_sat_flag", longint'(sat_flag), 0);
        checkOutput("clr_pix_cnt", longint'(pix_cnt), 0);

        stall_start = cyc + 5;
        stall_len   = 4;
        for (int i = 0; i < 8; i++) applyStimulus(longint'(i * 7 - 20), 1, 3, 1, 0, 0);
        waitDrain();
        checkOutput("bp_pix_cnt", longint'(pix_cnt), 8);
        stall_start = 1000000;
        stall_len   = 0;

        applyStimulus(10, 0, 0, 1, 0, 0);
        applyStimulus(20, 0, 0, 1, 0, 0);
        rst = 1'b1;
        m_acc = 0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("midrst_ofm_valid", longint'(bus.ofm_valid), 0);
        checkOutput("midrst_ofm_data", longint'(bus.ofm_data), 0);
        checkOutput("midrst_pix_cnt", longint'(pix_cnt), 0);
        checkOutput("midrst_sat_flag", longint'(sat_flag), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(30, 1, 0, 1, 0, 0);
        waitDrain();
        checkOutput("after_rst_pixel", last_out, 30);
        checkOutput("after_rst_pix_cnt", longint'(pix_cnt), 1);

        rand_bp = 1'b1;
        for (int p = 0; p < 40; p++) begin
            nt      = $urandom_range(1, 4);
            bias_r  = longint'($urandom_range(0, 1000)) - 500;
            relu_r  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) begin
                scale_r = longint'($urandom_range(0, 65535));
                shift_r = $urandom_range(0, 31);
            end else begin
                scale_r = longint'($urandom_range(0, 300));
                shift_r = $urandom_range(0, 12);
            end
            for (int t = 0; t < nt; t++) begin
                if ($urandom_range(0, 7) == 0) begin
                    r24 = ACC_W'($urandom);
                    d   = longint'(r24);
                end else begin
                    d = longint'($urandom_range(0, 4000)) - 2000;
                end
                applyStimulus(d, t == nt - 1, bias_r, scale_r, shift_r, relu_r);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        rand_bp = 1'b0;
        waitDrain();
        checkOutput("rand_queue_empty", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ofm_requant_pipe.md
Name: ofm_requant_pipe

Overview:
- Post-processing stage directly upstream of the OFM output buffer. Consumes partial sums from the PE array and accumulates them per output pixel.
- On the last partial sum of a pixel it applies bias add, optional ReLU, fixed-point rescale (multiply, rounding right shift) and 8-bit signed saturation.
- Emits one 8-bit OFM value per pixel through a valid/ready handshake.

Parameters:
ACC_W, 24, partial-sum/accumulator width (signed)
SCALE_W, 16, requant multiplier width (unsigned)
SHIFT_W, 5, requant shift amount width
CNT_W, 16, output pixel counter width

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
psum_valid  in  1  partial sum present
psum_ready  out  1  stage can accept a partial sum
psum_data  in  ACC_W  signed partial sum
psum_last  in  1  final partial sum of the current pixel
bias  in  ACC_W  signed bias, sampled with the last psum
scale  in  SCALE_W  unsigned multiplier, sampled with the last psum
shift  in  SHIFT_W  arithmetic right shift, sampled with the last psum
relu_en  in  1  ReLU enable, sampled with the last psum
stat_clr  in  1  synchronous clear of pix_cnt and sat_flag
ofm_valid  out  1  OFM value present
ofm_ready  in  1  downstream accepts
ofm_data  out  8  signed saturated OFM value
pix_cnt  out  CNT_W  OFM handshakes completed (wraps)
sat_flag  out  1  sticky: any output saturated since clear

Behaviour:
- Reset (async, rst=1) values:
  - ofm_valid=0, ofm_data=0, pix_cnt=0, sat_flag=0.
  - Accumulator=0 and first-flag=1.
  - All pipeline valid bits=0.
  - psum_ready=1 after reset deasserts.
- Accept rule: a psum is accepted when psum_valid & psum_ready.
- Stall rule:
  - stall = ofm_valid & ~ofm_ready.
  - While stall=1, all pipeline registers hold and psum_ready=0.
  - When stall=0, the pipeline advances every cycle; bubbles collapse only by advancing.
- Accumulate (stage A):
  - acc_next = (first ? 0 : acc) + psum_data, with two's-complement wrap at ACC_W.
  - On an accepted psum with psum_last=0: acc<=acc_next, first<=0.
  - On an accepted psum with psum_last=1: acc_next, bias, scale, shift and relu_en are captured into stage B; acc<=0; first<=1.
  - A single psum with last=1 forms a one-term pixel.
- Stage B (registered): x = sext(acc_next) + sext(bias), ACC_W+1 bits signed. If relu_en and x<0, then x=0.
- Stage C (registered): p = x * {0,scale}, signed, ACC_W+SCALE_W+2 bits.
- Output stage (registered):
  - r = (p + (shift==0 ? 0 : 1<<(shift-1))) >>> shift, arithmetic.
  - ofm_data = clamp(r, -128, 127).
  - If clamped, sat_flag<=1 when this value loads into the output register.
- Latency: last psum accepted in cycle t → ofm_valid=1 in cycle t+3, provided there is no stall.
- Throughput: one pixel per cycle when every psum carries last=1 and ofm_ready=1.
- Output hold: ofm_data and ofm_valid hold stable while ofm_valid=1 and ofm_ready=0.
- pix_cnt increments on each ofm_valid & ofm_ready and wraps at 2^CNT_W.
- stat_clr:
  - Sets pix_cnt=0 and sat_flag=0 next cycle.
  - If it coincides with a handshake or saturation event, the clear wins.
  - It does not affect datapath state.
- A pixel's accumulation may be interleaved with stall cycles; the partial accumulator is preserved.
- Reset mid-pixel discards the partial accumulator and all in-flight pixels. No ofm_valid is produced for them.

Test Plan:
1. Psums 10, 20, 30 (last on 30), bias=5, scale=1, shift=0, relu_en=0 → ofm_data=65, ofm_valid exactly 3 cycles after the last accept, pix_cnt=1.
2. Single psum -100 with last=1, bias=0, scale=1, shift=0: relu_en=1 → 0; relu_en=0 → -100.
3. Rounding: acc=7, scale=3, shift=2 → (21+2)>>2 = 5; acc=-7 → (-21+2)>>>2 = -5.
4. Saturation: acc=1000, scale=1, shift=0 → 127 and sat_flag=1; acc=-1000 → -128; stat_clr then → sat_flag=0, pix_cnt=0.
5. Backpressure: stream 8 one-term pixels with ofm_ready low for 4 cycles mid-stream → psum_ready=0 during the stall, ofm_data stable, all 8 values delivered in order, pix_cnt=8.
6. Assert rst for 1 cycle after 2 of 3 psums → outputs zero; the next pixel accumulates from 0, with no stale value emitted.
